// File: rtl/usb_data_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_data_buffer_if
// Brief    : Push/pop/status bundle shared by the USB data buffer and its users.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_data_buffer_if #(
    parameter int ADDR_BITS = 6
);
    logic                 clear;
    logic                 flush;
    logic                 store_tx_data;
    logic [7:0]           tx_data;
    logic                 store_rx_packet_data;
    logic [7:0]           rx_packet_data;
    logic                 get_tx_packet_data;
    logic                 get_rx_data;
    logic [7:0]           tx_packet_data;
    logic [7:0]           rx_data;
    logic [ADDR_BITS:0]   buffer_occupancy;
    logic                 overflow_err;
    logic                 underflow_err;

    modport slave (
        input  clear, flush, store_tx_data, tx_data, store_rx_packet_data,
               rx_packet_data, get_tx_packet_data, get_rx_data,
        output tx_packet_data, rx_data, buffer_occupancy, overflow_err,
               underflow_err
    );

    modport master (
        output clear, flush, store_tx_data, tx_data, store_rx_packet_data,
               rx_packet_data, get_tx_packet_data, get_rx_data,
        input  tx_packet_data, rx_data, buffer_occupancy, overflow_err,
               underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/usb_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : usb_data_buffer
// Brief    : Circular first-word-fall-through byte buffer between bus and USB.
// Revision : 1.0 - initial release
// ============================================================================
module usb_data_buffer #(
    parameter int ADDR_BITS = 6
) (
    input  wire                     clk,
    input  wire                     n_rst,
    usb_data_buffer_if.slave        bus
);
    localparam int unsigned            c_depth   = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]     c_full    = c_depth[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]     c_occ_one = 1;
    localparam logic [ADDR_BITS-1:0]   c_ptr_one = 1;

    logic [7:0]           mem_q [c_depth];
    logic [7:0]           mem_d [c_depth];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   occ_q, occ_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic                 w_clr;
    logic                 w_push_req;
    logic                 w_pop_req;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop_ok;
    logic                 w_push_ok;
    logic [7:0]           w_wr_data;
    logic [7:0]           w_head;

    always_comb begin
        w_clr      = bus.clear | bus.flush;
        w_push_req = bus.store_tx_data | bus.store_rx_packet_data;
        w_pop_req  = bus.get_tx_packet_data | bus.get_rx_data;
        w_empty    = (occ_q == '0);
        w_full     = (occ_q == c_full);
        w_pop_ok   = w_pop_req & ~w_empty;
        // A pop in the same cycle frees the slot a full-buffer push needs.
        w_push_ok  = w_push_req & (~w_full | w_pop_ok);
        w_wr_data  = bus.store_tx_data ? bus.tx_data : bus.rx_packet_data;
        w_head     = w_empty ? 8'h00 : mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (w_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (w_push_ok) begin
                mem_d[wr_ptr_q] = w_wr_data;
                wr_ptr_d        = wr_ptr_q + c_ptr_one;
            end
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   occ_d = occ_q + c_occ_one;
                2'b01:   occ_d = occ_q - c_occ_one;
                default: occ_d = occ_q;
            endcase
            // Dual store strobes lose the rx byte, which is reported as overflow.
            overflow_d  = (w_push_req & ~w_push_ok) |
                          (bus.store_tx_data & bus.store_rx_packet_data);
            underflow_d = w_pop_req & w_empty;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < c_depth; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.tx_packet_data   = w_head;
    assign bus.rx_data          = w_head;
    assign bus.buffer_occupancy = occ_q;
    assign bus.overflow_err     = overflow_q;
    assign bus.underflow_err    = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_usb_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_data_buffer
// Brief    : Directed self-checking bench for usb_data_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_data_buffer;
    localparam int ADDR_BITS = 6;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_err;

    usb_data_buffer_if #(.ADDR_BITS(ADDR_BITS)) bus_if ();

    usb_data_buffer #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus_if.clear                = 1'b0;
        bus_if.flush                = 1'b0;
        bus_if.store_tx_data        = 1'b0;
        bus_if.tx_data              = 8'h00;
        bus_if.store_rx_packet_data = 1'b0;
        bus_if.rx_packet_data       = 8'h00;
        bus_if.get_tx_packet_data   = 1'b0;
        bus_if.get_rx_data          = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        bus_if.store_tx_data = 1'b1;
        bus_if.tx_data       = d;
        tick();
        idle();
    endtask

    task automatic pop_tx();
        bus_if.get_tx_packet_data = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_rst = 1'b0;
        idle();
        #2;
        check("rst_occ",  32'(bus_if.buffer_occupancy), 0);
        check("rst_head", 32'(bus_if.tx_packet_data), 8'h00);
        check("rst_ovf",  32'(bus_if.overflow_err), 0);
        check("rst_unf",  32'(bus_if.underflow_err), 0);
        tick();
        n_rst = 1'b1;
        tick();

        // Basic push/pop ordering
        push_tx(8'hA5);
        check("p1_occ", 32'(bus_if.buffer_occupancy), 1);
        check("p1_head", 32'(bus_if.tx_packet_data), 8'hA5);
        push_tx(8'h3C);
        check("p2_occ", 32'(bus_if.buffer_occupancy), 2);
        check("p2_head", 32'(bus_if.tx_packet_data), 8'hA5);
        pop_tx();
        check("pop_head_tx", 32'(bus_if.tx_packet_data), 8'h3C);
        check("pop_head_rx", 32'(bus_if.rx_data), 8'h3C);
        check("pop_occ", 32'(bus_if.buffer_occupancy), 1);
        bus_if.get_tx_packet_data = 1'b1;
        bus_if.get_rx_data        = 1'b1;
        tick();
        idle();
        check("dualpop_occ", 32'(bus_if.buffer_occupancy), 0);
        check("dualpop_unf", 32'(bus_if.underflow_err), 0);
        check("dualpop_head", 32'(bus_if.tx_packet_data), 8'h00);

        // Fill to 64, overflow, drain across pointer wrap
        for (int i = 0; i < 64; i++) push_tx(8'(i));
        check("fill_occ", 32'(bus_if.buffer_occupancy), 64);
        check("fill_head", 32'(bus_if.tx_packet_data), 8'h00);
        push_tx(8'hFF);
        check("ovf_pulse", 32'(bus_if.overflow_err), 1);
        check("ovf_occ", 32'(bus_if.buffer_occupancy), 64);
        tick();
        check("ovf_clear", 32'(bus_if.overflow_err), 0);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("drain_%0d", i), 32'(bus_if.tx_packet_data), 32'(i));
            pop_tx();
        end
        check("drain_occ", 32'(bus_if.buffer_occupancy), 0);

        // Underflow, and push accepted alongside an empty pop
        bus_if.get_rx_data = 1'b1;
        tick();
        idle();
        check("unf_pulse", 32'(bus_if.underflow_err), 1);
        check("unf_occ", 32'(bus_if.buffer_occupancy), 0);
        check("unf_rx", 32'(bus_if.rx_data), 8'h00);
        tick();
        check("unf_clear", 32'(bus_if.underflow_err), 0);
        bus_if.get_rx_data   = 1'b1;
        bus_if.store_tx_data = 1'b1;
        bus_if.tx_data       = 8'h42;
        tick();
        idle();
        check("unfpush_unf", 32'(bus_if.underflow_err), 1);
        check("unfpush_occ", 32'(bus_if.buffer_occupancy), 1);
        check("unfpush_head", 32'(bus_if.rx_data), 8'h42);
        pop_tx();

        // Full buffer: push with same-cycle pop is accepted
        for (int i = 0; i < 64; i++) push_tx(8'(i));
        bus_if.store_tx_data      = 1'b1;
        bus_if.tx_data            = 8'h77;
        bus_if.get_tx_packet_data = 1'b1;
        tick();
        idle();
        check("fullpp_occ", 32'(bus_if.buffer_occupancy), 64);
        check("fullpp_ovf", 32'(bus_if.overflow_err), 0);
        for (int j = 0; j < 64; j++) begin
            check($sformatf("fullpp_pop_%0d", j), 32'(bus_if.tx_packet_data),
                  (j < 63) ? 32'(j + 1) : 32'h77);
            pop_tx();
        end
        check("fullpp_end", 32'(bus_if.buffer_occupancy), 0);

        // Flush overrides same-cycle push and pop
        for (int i = 0; i < 10; i++) push_tx(8'(8'h80 + i));
        check("pre_flush_occ", 32'(bus_if.buffer_occupancy), 10);
        bus_if.flush              = 1'b1;
        bus_if.store_tx_data      = 1'b1;
        bus_if.tx_data            = 8'hEE;
        bus_if.get_tx_packet_data = 1'b1;
        tick();
        idle();
        check("flush_occ", 32'(bus_if.buffer_occupancy), 0);
        check("flush_tx", 32'(bus_if.tx_packet_data), 8'h00);
        check("flush_rx", 32'(bus_if.rx_data), 8'h00);
        check("flush_ovf", 32'(bus_if.overflow_err), 0);
        check("flush_unf", 32'(bus_if.underflow_err), 0);
        push_tx(8'h5C);
        bus_if.clear = 1'b1;
        tick();
        idle();
        check("clear_occ", 32'(bus_if.buffer_occupancy), 0);

        // Dual store strobes: tx wins, overflow reported
        bus_if.store_tx_data        = 1'b1;
        bus_if.tx_data              = 8'h11;
        bus_if.store_rx_packet_data = 1'b1;
        bus_if.rx_packet_data       = 8'h22;
        tick();
        idle();
        check("dual_occ", 32'(bus_if.buffer_occupancy), 1);
        check("dual_head", 32'(bus_if.tx_packet_data), 8'h11);
        check("dual_ovf", 32'(bus_if.overflow_err), 1);
        tick();
        check("dual_ovf_clr", 32'(bus_if.overflow_err), 0);
        bus_if.store_rx_packet_data = 1'b1;
        bus_if.rx_packet_data       = 8'h33;
        tick();
        idle();
        check("rxpush_occ", 32'(bus_if.buffer_occupancy), 2);
        pop_tx();
        check("rxpush_head", 32'(bus_if.tx_packet_data), 8'h33);

        // Asynchronous reset mid-fill, then push in the release cycle
        push_tx(8'h44);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_occ", 32'(bus_if.buffer_occupancy), 0);
        check("arst_head", 32'(bus_if.tx_packet_data), 8'h00);
        check("arst_ovf", 32'(bus_if.overflow_err), 0);
        tick();
        n_rst                = 1'b1;
        bus_if.store_tx_data = 1'b1;
        bus_if.tx_data       = 8'h5A;
        tick();
        idle();
        check("rel_occ", 32'(bus_if.buffer_occupancy), 1);
        check("rel_head", 32'(bus_if.tx_packet_data), 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
